// File: rtl/nibble_serial_sub8.sv
// Serial 8-bit subtractor: computes A - B - bin one 4-bit nibble per cycle.
// The low nibble is computed in LO and the high nibble in HI. Results are published only on completion.
module nibble_serial_sub8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] diff,
  output logic       bout,
  output logic       zero,
  output logic       ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_bin;
  logic [3:0] r_loDiff;
  logic       r_loBorrow;
  logic       r_done;
  logic [7:0] r_diff;
  logic       r_bout;
  logic       r_zero;
  logic       r_ovf;

  logic [4:0] w_loSum;
  logic [4:0] w_hiSum;
  logic [7:0] w_diff;

  // Bit 4 of a 5-bit nibble difference is the borrow out of that nibble.
  assign w_loSum = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'b0000, r_bin};
  assign w_hiSum = {1'b0, r_a[7:4]} - {1'b0, r_b[7:4]} - {4'b0000, r_loBorrow};
  assign w_diff  = {w_hiSum[3:0], r_loDiff};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_bin      <= 1'b0;
      r_loDiff   <= 4'h0;
      r_loBorrow <= 1'b0;
      r_done     <= 1'b0;
      r_diff     <= 8'h00;
      r_bout     <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_bin   <= bin;
            r_state <= LO;
          end
        end
        LO: begin
          r_loDiff   <= w_loSum[3:0];
          r_loBorrow <= w_loSum[4];
          r_state    <= HI;
        end
        HI: begin
          r_diff  <= w_diff;
          r_bout  <= w_hiSum[4];
          r_zero  <= (w_diff == 8'h00);
          r_ovf   <= (r_a[7] != r_b[7]) && (w_diff[7] != r_a[7]);
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;
  assign ovf  = r_ovf;

endmodule

// File: doc/nibble_serial_sub8.md
NIBBLE_SERIAL_SUB8 -- requirements
Module: nibble_serial_sub8

Interface
REQ-001 Parameters: none; all widths fixed at 8-bit operands and 4-bit slice.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while the block is idle.
REQ-005 A  input  8  unsigned minuend; sampled with an accepted start.
REQ-006 B  input  8  unsigned subtrahend; sampled with an accepted start.
REQ-007 bin  input  1  borrow-in; sampled with an accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid, newly updated results.
REQ-010 diff  output  8  result, A - B - bin modulo 256.
REQ-011 bout  output  1  borrow out of bit 7; 1 iff A < B + bin as unsigned values.
REQ-012 zero  output  1  1 iff diff == 8'h00.
REQ-013 ovf  output  1  signed overflow: (A[7] != B[7]) && (diff[7] != A[7]).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LO, HI.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL capture A, B and bin into internal registers, move to LO, and raise busy.
REQ-016 In LO, the block SHALL compute A[3:0] - B[3:0] - bin, store the 4-bit result and the nibble borrow internally, and move to HI.
REQ-017 In HI, the block SHALL compute A[7:4] - B[7:4] - (stored nibble borrow) and then:
  - load diff, bout, zero and ovf in the same edge;
  - assert done;
  - return to IDLE.
REQ-018 Latency: for start accepted at edge k, busy SHALL be high after edges k and k+1, and done plus the new results SHALL be visible after edge k+2.
REQ-019 done SHALL be high for exactly one cycle per accepted operation, and SHALL never be high while busy=1.
REQ-020 diff, bout, zero and ovf SHALL hold their values from the previous completion until the next completion; intermediate nibble results SHALL never appear on the outputs.
REQ-021 start while busy=1 SHALL be ignored without side effects, including any change to captured operands.
REQ-022 A, B and bin changing after acceptance SHALL NOT affect the operation in flight.
REQ-023 Back-to-back operation: start=1 in the cycle done=1 (state IDLE) SHALL be accepted, giving a 3-cycle initiation interval.
REQ-024 The nibble borrow SHALL propagate correctly in all cases, including a low-nibble borrow that turns into a high-nibble borrow, e.g. 8'h00 - 8'h01.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force:
  - state=IDLE;
  - busy=0, done=0;
  - diff=8'h00, bout=0, zero=0, ovf=0;
  - all internal operand and borrow registers to 0.
REQ-026 Reset asserted in LO or HI SHALL abort the operation; no done pulse and no result update SHALL follow.
REQ-027 In the first rising edge after rst deasserts, start=1 SHALL be accepted normally.

Verification
REQ-028 Basic subtract: A=8'h3C, B=8'h15, bin=0 -> two edges after acceptance, diff=8'h27, bout=0, zero=0, ovf=0, done pulses once.
REQ-029 Full borrow chain: A=8'h00, B=8'h01, bin=0 -> diff=8'hFF, bout=1, ovf=0, zero=0.
REQ-030 Signed overflow: A=8'h80, B=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1.
REQ-031 Zero with borrow-in and nibble borrow: A=8'h10, B=8'h0F, bin=1 -> diff=8'h00, zero=1, bout=0, ovf=0.
REQ-032 Handshake: start held high continuously with A/B changing every cycle -> only the operands present at acceptance edges are used; results appear every 3 cycles; busy never overlaps done.
REQ-033 Reset abort: assert rst while in LO -> busy=0 and outputs zero immediately; no done pulse; a new start after release completes correctly.
